// File: rtl/audio_frame_packer.sv
// Pairs left/right decoder samples into stereo frames and queues them in a small FWFT FIFO.
// Optional drop counter enabled by defining AUDIO_FRAME_PACKER_DROP_COUNT_EN.
module audio_frame_packer #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     sclk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_is_left,
  input  logic [31:0]              s_audio,
  input  logic                     s_error,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [W-1:0]             m_left,
  output logic [W-1:0]             m_right,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {WAIT_LEFT = 1'b0, WAIT_RIGHT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  hold_left_q, hold_left_d;
  logic [W-1:0]  sample;
  logic [W-1:0]  mem_left_q  [DEPTH];
  logic [W-1:0]  mem_right_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          full, accept, push, pop;
  logic [1:0]    drops;
  logic          unused_audio;

  assign sample       = s_audio[31 -: W];
  assign unused_audio = ^s_audio;
  assign full         = (level_q == FULL_LVL);
  // Depends on registered state only; no path from m_ready.
  assign s_ready      = (state_q == WAIT_LEFT) || !full;
  assign accept       = s_valid && s_ready;
  assign m_valid      = (level_q != '0);
  assign pop          = m_valid && m_ready;
  assign fifo_level   = level_q;
  assign m_left       = mem_left_q[rd_ptr_q];
  assign m_right      = mem_right_q[rd_ptr_q];

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LEFT;
      hold_left_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_left_q <= hold_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_left_d = hold_left_q;
    if (s_error) begin
      state_d = WAIT_LEFT;
    end else if (accept) begin
      if (s_is_left) begin
        hold_left_d = sample;
        state_d     = WAIT_RIGHT;
      end else begin
        state_d = WAIT_LEFT;
      end
    end
  end

  always_comb begin
    push  = 1'b0;
    drops = 2'd0;
    if (s_error) begin
      // Both the incoming sample and a pending left can be lost in one cycle.
      drops = {1'b0, accept} + {1'b0, (state_q == WAIT_RIGHT)};
    end else if (accept) begin
      if (state_q == WAIT_LEFT) begin
        drops = s_is_left ? 2'd0 : 2'd1;
      end else begin
        push  = !s_is_left;
        drops = s_is_left ? 2'd1 : 2'd0;
      end
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (push) begin
      mem_left_q[wr_ptr_q]  <= hold_left_q;
      mem_right_q[wr_ptr_q] <= sample;
    end
  end

`ifdef AUDIO_FRAME_PACKER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  assign drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drops};
  assign drop_count = drop_cnt_q;

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`else
  logic unused_drops;
  assign unused_drops = ^drops;
  assign drop_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_frame_packer.sv
// Bench for audio_frame_packer: vector table plus frame scoreboard and multi-cycle corner sequences.
module tb_audio_frame_packer;

  logic        sclk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_is_left = 1'b0;
  logic [31:0] s_audio = '0;
  logic        s_error = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_left, m_right;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;
  int exp_drops = 0;

  typedef struct { logic [23:0] l; logic [23:0] r; } frame_t;
  frame_t sb[$];

  typedef struct {
    logic v; logic il; logic [31:0] aud; logic err;
    logic exp_rdy; logic exp_push; logic [23:0] exp_l; logic [23:0] exp_r; int exp_drops;
  } vec_t;
  vec_t tbl[16];

  always #5 sclk = ~sclk;

  audio_frame_packer #(.DEPTH(4), .W(24)) dut (
    .sclk(sclk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_is_left(s_is_left), .s_audio(s_audio), .s_error(s_error),
    .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  function automatic logic [15:0] dc(input int n);
`ifdef AUDIO_FRAME_PACKER_DROP_COUNT_EN
    dc = (n > 65535) ? 16'hFFFF : 16'(n);
`else
    dc = 16'h0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every frame taken by the consumer must match the oldest expected frame.
  always @(negedge sclk) begin
    if (!reset && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'(m_left), 32'hDEAD_BEEF);
      end else begin
        frame_t f;
        f = sb.pop_front();
        chk("frame_left", 32'(m_left), 32'(f.l));
        chk("frame_right", 32'(m_right), 32'(f.r));
      end
    end
  end

  task automatic tick();
    @(posedge sclk); #1;
  endtask

  task automatic send(input logic il, input logic [31:0] aud);
    s_valid = 1'b1; s_is_left = il; s_audio = aud;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [23:0] l, input logic [23:0] r);
    frame_t f;
    f.l = l; f.r = r;
    sb.push_back(f);
  endtask

  task automatic drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    while (fifo_level != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'hAABBCC00, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 0};
    tbl[1]  = '{1'b1, 1'b0, 32'h11223300, 1'b0, 1'b1, 1'b1, 24'hAABBCC, 24'h112233, 0};
    tbl[2]  = '{1'b1, 1'b0, 32'h99999900, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 1};
    tbl[3]  = '{1'b1, 1'b1, 32'h01020300, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 1};
    tbl[4]  = '{1'b1, 1'b0, 32'h04050600, 1'b0, 1'b1, 1'b1, 24'h010203, 24'h040506, 1};
    tbl[5]  = '{1'b1, 1'b1, 32'h0A0B0C00, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 1};
    tbl[6]  = '{1'b1, 1'b1, 32'h0D0E0F00, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 2};
    tbl[7]  = '{1'b1, 1'b0, 32'h10203000, 1'b0, 1'b1, 1'b1, 24'h0D0E0F, 24'h102030, 2};
    tbl[8]  = '{1'b1, 1'b1, 32'h55555500, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0, 3};
    tbl[9]  = '{1'b1, 1'b1, 32'h66666600, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 3};
    tbl[10] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0, 4};
    tbl[11] = '{1'b1, 1'b1, 32'h77777700, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0, 5};
    tbl[12] = '{1'b1, 1'b1, 32'h88888800, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 5};
    tbl[13] = '{1'b1, 1'b0, 32'h99AABB00, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0, 7};
    tbl[14] = '{1'b1, 1'b1, 32'h123456FF, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 7};
    tbl[15] = '{1'b1, 1'b0, 32'hABCDEF77, 1'b0, 1'b1, 1'b1, 24'h123456, 24'hABCDEF, 7};

    // Reset state
    tick();
    reset = 1'b1;
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_drop", 32'(drop_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Table: m_ready held high, so a pushed frame is visible for exactly one cycle.
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = tbl[i].v; s_is_left = tbl[i].il; s_audio = tbl[i].aud; s_error = tbl[i].err;
      if (tbl[i].exp_push) push_exp(tbl[i].exp_l, tbl[i].exp_r);
      @(negedge sclk);
      chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].exp_rdy));
      tick();
      s_valid = 1'b0; s_error = 1'b0;
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].exp_push));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'(dc(tbl[i].exp_drops)));
    end
    exp_drops = 7;
    tick();
    chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // Full FIFO back-pressure
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, {8'(8'h20 + i), 16'h1111, 8'h00});
      send(1'b0, {8'(8'h30 + i), 16'h2222, 8'h00});
      push_exp({8'(8'h20 + i), 16'h1111}, {8'(8'h30 + i), 16'h2222});
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ready_wait_left", 32'(s_ready), 32'd1);
    send(1'b1, 32'h5A5A5A00);
    s_valid = 1'b1; s_is_left = 1'b0; s_audio = 32'hA5A5A500;
    @(negedge sclk);
    chk("full_ready_wait_right", 32'(s_ready), 32'd0);
    tick();
    @(negedge sclk);
    chk("full_ready_hold", 32'(s_ready), 32'd0);
    chk("full_level_hold", 32'(fifo_level), 32'd4);
    chk("full_head_stable", 32'(m_left), 32'h201111);
    tick();
    m_ready = 1'b1;
    push_exp(24'h5A5A5A, 24'hA5A5A5);
    @(negedge sclk);
    chk("no_mready_path", 32'(s_ready), 32'd0);
    tick();
    @(negedge sclk);
    chk("ready_after_pop", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("push_pop_level", 32'(fifo_level), 32'd3);
    drain();
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Error while holding a left sample
    m_ready = 1'b0;
    send(1'b1, 32'hC0C0C000);
    send(1'b0, 32'hC1C1C100);
    push_exp(24'hC0C0C0, 24'hC1C1C1);
    send(1'b1, 32'hC2C2C200);
    s_error = 1'b1;
    tick();
    s_error = 1'b0;
    exp_drops++;
    chk("err_level", 32'(fifo_level), 32'd1);
    chk("err_drop", 32'(drop_count), 32'(dc(exp_drops)));
    send(1'b0, 32'hC3C3C300);
    exp_drops++;
    chk("err_lone_right_level", 32'(fifo_level), 32'd1);
    chk("err_lone_right_drop", 32'(drop_count), 32'(dc(exp_drops)));
    send(1'b1, 32'hC4C4C400);
    send(1'b0, 32'hC5C5C500);
    push_exp(24'hC4C4C4, 24'hC5C5C5);
    chk("err_repack_level", 32'(fifo_level), 32'd2);
    drain();
    chk("err_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset with a full FIFO and a held left sample
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, {8'(8'h40 + i), 24'h0});
      send(1'b0, {8'(8'h50 + i), 24'h0});
    end
    send(1'b1, 32'h66000000);
    chk("pre_rst_level", 32'(fifo_level), 32'd4);
    chk("pre_rst_ready", 32'(s_ready), 32'd0);
    chk("pre_rst_drop", 32'(drop_count), 32'(dc(exp_drops)));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_level", 32'(fifo_level), 32'd0);
    chk("async_rst_ready", 32'(s_ready), 32'd1);
    chk("async_rst_drop", 32'(drop_count), 32'd0);
    tick();
    reset = 1'b0;
    exp_drops = 0;
    tick();
    m_ready = 1'b1;
    send(1'b1, 32'h77000000);
    send(1'b0, 32'h88000000);
    push_exp(24'h770000, 24'h880000);
    tick();
    chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

`ifdef AUDIO_FRAME_PACKER_DROP_COUNT_EN
    // Counter saturation on a stream of right-only samples
    s_valid = 1'b1; s_is_left = 1'b0; s_audio = 32'h01000000;
    repeat (65540) @(posedge sclk);
    #1;
    chk("sat_drop", 32'(drop_count), 32'hFFFF);
    repeat (3) @(posedge sclk);
    #1;
    chk("sat_hold", 32'(drop_count), 32'hFFFF);
    s_valid = 1'b0;
    chk("sat_level", 32'(fifo_level), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
